// File: rtl/alu_issue_wb.sv
// alu_issue_wb: issue/writeback sequencer wrapped around a combinational ALU.
// It accepts one request at a time and drives its opcode and operands onto the
// ALU. After a programmable settle window it captures the 64-bit result, then
// retires it as one GPR beat, or as a HI beat followed by a LO beat for
// mul/div.
//
// state    | meaning
// IDLE     | waiting for a request (blocked once halted)
// SETTLE   | ALU inputs held, settle counter running down
// DISPATCH | classify the captured opcode, arm the first writeback beat
// WB_GPR   | single GPR beat pending
// WB_HI    | HI beat of mul/div pending
// WB_LO    | LO beat of mul/div pending
module alu_issue_wb #(
  parameter int SETTLE_CYCLES = 2,
  parameter int RD_W          = 4
) (
  input  logic            clk,
  input  logic            clear,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [4:0]      req_opcode,
  input  logic [31:0]     req_a,
  input  logic [31:0]     req_b,
  input  logic [RD_W-1:0] req_rd,
  output logic [4:0]      alu_opcode,
  output logic [31:0]     alu_a,
  output logic [31:0]     alu_b,
  input  logic [63:0]     alu_c,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [1:0]      wb_sel,
  output logic [RD_W-1:0] wb_addr,
  output logic [31:0]     wb_data,
  output logic            halted,
  output logic            op_err,
  output logic            busy
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] SETTLE   = 3'd1;
  localparam logic [2:0] DISPATCH = 3'd2;
  localparam logic [2:0] WB_GPR   = 3'd3;
  localparam logic [2:0] WB_HI    = 3'd4;
  localparam logic [2:0] WB_LO    = 3'd5;

  localparam logic [4:0] OP_NOP      = 5'b11001;
  localparam logic [3:0] CNT_INIT    = 4'(SETTLE_CYCLES - 1);

  localparam logic [1:0] SEL_GPR = 2'd0;
  localparam logic [1:0] SEL_HI  = 2'd1;
  localparam logic [1:0] SEL_LO  = 2'd2;

  logic [2:0]      r_state;
  logic [3:0]      r_cnt;
  logic [63:0]     r_z;
  logic [4:0]      r_alu_opcode;
  logic [31:0]     r_alu_a;
  logic [31:0]     r_alu_b;
  logic [RD_W-1:0] r_rd;
  logic            r_wb_valid;
  logic [1:0]      r_wb_sel;
  logic [RD_W-1:0] r_wb_addr;
  logic [31:0]     r_wb_data;
  logic            r_halted;
  logic            r_op_err;

  logic w_req_ready;
  logic w_accept;
  logic w_wb_fire;
  logic w_to_hi;
  logic w_no_wb;
  logic w_halt;
  logic w_undef;

  assign w_req_ready = (r_state == IDLE) && !r_halted;
  assign w_accept    = req_valid && w_req_ready;
  assign w_wb_fire   = r_wb_valid && wb_ready;

  // Classify the opcode held on the ALU inputs; only consulted in DISPATCH.
  always_comb begin
    w_to_hi = 1'b0;
    w_no_wb = 1'b0;
    w_halt  = 1'b0;
    w_undef = 1'b0;
    case (r_alu_opcode)
      5'b01110, 5'b01111:                         w_to_hi = 1'b1;
      5'b00010, 5'b10010, 5'b10011, 5'b10110,
      5'b11001:                                   w_no_wb = 1'b1;
      5'b11010:                                   w_halt  = 1'b1;
      5'b11011, 5'b11100, 5'b11101, 5'b11110,
      5'b11111:                                   w_undef = 1'b1;
      default: ;
    endcase
  end

  // Sequencer state, settle counter, ALU input registers and result capture.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_state      <= IDLE;
      r_cnt        <= 4'd0;
      r_z          <= 64'd0;
      r_alu_opcode <= OP_NOP;
      r_alu_a      <= 32'd0;
      r_alu_b      <= 32'd0;
      r_rd         <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_alu_opcode <= req_opcode;
            r_alu_a      <= req_a;
            r_alu_b      <= req_b;
            r_rd         <= req_rd;
            r_cnt        <= CNT_INIT;
            r_state      <= SETTLE;
          end
        end
        SETTLE: begin
          if (r_cnt == 4'd0) begin
            r_z     <= alu_c;
            r_state <= DISPATCH;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        DISPATCH: begin
          if (w_to_hi)
            r_state <= WB_HI;
          else if (w_no_wb || w_halt || w_undef)
            r_state <= IDLE;
          else
            r_state <= WB_GPR;
        end
        WB_GPR:  if (w_wb_fire) r_state <= IDLE;
        WB_HI:   if (w_wb_fire) r_state <= WB_LO;
        WB_LO:   if (w_wb_fire) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Registered writeback beat; fields only change on arming or on a handshake.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_wb_valid <= 1'b0;
      r_wb_sel   <= SEL_GPR;
      r_wb_addr  <= '0;
      r_wb_data  <= 32'd0;
    end else begin
      case (r_state)
        DISPATCH: begin
          if (w_to_hi) begin
            r_wb_valid <= 1'b1;
            r_wb_sel   <= SEL_HI;
            r_wb_data  <= r_z[63:32];
          end else if (!(w_no_wb || w_halt || w_undef)) begin
            r_wb_valid <= 1'b1;
            r_wb_sel   <= SEL_GPR;
            r_wb_addr  <= r_rd;
            r_wb_data  <= r_z[31:0];
          end
        end
        WB_HI: begin
          if (w_wb_fire) begin
            r_wb_sel  <= SEL_LO;
            r_wb_data <= r_z[31:0];
          end
        end
        WB_GPR, WB_LO: begin
          if (w_wb_fire) r_wb_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Sticky halt and undefined-opcode flags, released only by clear.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_halted <= 1'b0;
      r_op_err <= 1'b0;
    end else if (r_state == DISPATCH) begin
      if (w_halt)  r_halted <= 1'b1;
      if (w_undef) r_op_err <= 1'b1;
    end
  end

  assign req_ready  = w_req_ready;
  assign busy       = (r_state != IDLE);
  assign alu_opcode = r_alu_opcode;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign wb_valid   = r_wb_valid;
  assign wb_sel     = r_wb_sel;
  assign wb_addr    = r_wb_addr;
  assign wb_data    = r_wb_data;
  assign halted     = r_halted;
  assign op_err     = r_op_err;

endmodule

// File: tb/tb_alu_issue_wb.sv
// Directed bench for alu_issue_wb with SETTLE_CYCLES=2.
// Inputs change and outputs are sampled 1 ns after the rising edge.
module tb_alu_issue_wb;

  logic        clk = 1'b0;
  logic        clear;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_opcode;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [3:0]  req_rd;
  logic [4:0]  alu_opcode;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [63:0] alu_c;
  logic        wb_valid;
  logic        wb_ready;
  logic [1:0]  wb_sel;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
  logic        halted;
  logic        op_err;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  alu_issue_wb #(.SETTLE_CYCLES(2), .RD_W(4)) dut (
    .clk(clk), .clear(clear),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_a(req_a), .req_b(req_b), .req_rd(req_rd),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_sel(wb_sel),
    .wb_addr(wb_addr), .wb_data(wb_data),
    .halted(halted), .op_err(op_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for exactly one rising edge; returns 1 ns after that edge.
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] rd);
    req_valid  = 1'b1;
    req_opcode = op;
    req_a      = a;
    req_b      = b;
    req_rd     = rd;
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    clear      = 1'b1;
    req_valid  = 1'b0;
    req_opcode = 5'd0;
    req_a      = 32'd0;
    req_b      = 32'd0;
    req_rd     = 4'd0;
    alu_c      = 64'd0;
    wb_ready   = 1'b0;
    tick();
    tick();
    chk("rst_alu_opcode", 64'(alu_opcode), 64'h19);
    chk("rst_alu_a", 64'(alu_a), 64'd0);
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_wb_data", 64'(wb_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_flags", {62'd0, halted, op_err}, 64'd0);
    clear = 1'b0;
    tick();
    chk("rst_req_ready", 64'(req_ready), 64'd1);

    // add 5+7 -> rd 3
    alu_c    = 64'd12;
    wb_ready = 1'b1;
    issue(5'b00011, 32'd5, 32'd7, 4'd3);
    chk("add_busy", 64'(busy), 64'd1);
    chk("add_req_ready_low", 64'(req_ready), 64'd0);
    chk("add_alu_in0", {27'd0, alu_opcode, alu_a}, {27'd0, 5'b00011, 32'd5});
    chk("add_alu_b0", 64'(alu_b), 64'd7);
    tick();
    chk("add_alu_in1", {27'd0, alu_opcode, alu_a}, {27'd0, 5'b00011, 32'd5});
    chk("add_no_early_wb", 64'(wb_valid), 64'd0);
    tick();
    chk("add_dispatch_no_wb", 64'(wb_valid), 64'd0);
    tick();
    chk("add_beat", {wb_valid, 25'd0, wb_sel, wb_addr, wb_data}, {1'b1, 25'd0, 2'd0, 4'd3, 32'd12});
    tick();
    chk("add_done_valid", 64'(wb_valid), 64'd0);
    chk("add_done_ready", 64'(req_ready), 64'd1);
    chk("add_done_busy", 64'(busy), 64'd0);
    tick();
    chk("add_no_second_beat", 64'(wb_valid), 64'd0);

    // capture isolation: alu_c changes right after the capture edge
    alu_c = 64'd12;
    issue(5'b00011, 32'd1, 32'd11, 4'd5);
    tick();
    tick();
    alu_c = 64'hFFFF;
    tick();
    chk("iso_beat", {wb_valid, 25'd0, wb_sel, wb_addr, wb_data}, {1'b1, 25'd0, 2'd0, 4'd5, 32'd12});
    tick();
    chk("iso_done", 64'(wb_valid), 64'd0);

    // mul, no backpressure
    alu_c = 64'h0000_0001_8000_0000;
    issue(5'b01110, 32'h3, 32'h8000_0000, 4'd1);
    tick();
    tick();
    tick();
    chk("mul_hi", {wb_valid, 29'd0, wb_sel, wb_data}, {1'b1, 29'd0, 2'd1, 32'h1});
    tick();
    chk("mul_lo", {wb_valid, 29'd0, wb_sel, wb_data}, {1'b1, 29'd0, 2'd2, 32'h8000_0000});
    chk("mul_lo_busy", 64'(busy), 64'd1);
    tick();
    chk("mul_done", {62'd0, wb_valid, busy}, 64'd0);

    // mul with the sink stalled for 5 cycles on the HI beat
    wb_ready = 1'b0;
    issue(5'b01111, 32'h3, 32'h8000_0000, 4'd1);
    tick();
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_hold%0d", i), {wb_valid, 29'd0, wb_sel, wb_data}, {1'b1, 29'd0, 2'd1, 32'h1});
      tick();
    end
    chk("bp_hold_last", {wb_valid, 29'd0, wb_sel, wb_data}, {1'b1, 29'd0, 2'd1, 32'h1});
    wb_ready = 1'b1;
    tick();
    chk("bp_lo", {wb_valid, 29'd0, wb_sel, wb_data}, {1'b1, 29'd0, 2'd2, 32'h8000_0000});
    tick();
    chk("bp_done", 64'(wb_valid), 64'd0);

    // store: no writeback, busy drops after dispatch
    alu_c = 64'd99;
    issue(5'b00010, 32'd4, 32'd4, 4'd2);
    tick();
    chk("st_wb0", 64'(wb_valid), 64'd0);
    tick();
    chk("st_busy_dispatch", {62'd0, wb_valid, busy}, 64'd1);
    tick();
    chk("st_idle", {62'd0, wb_valid, busy}, 64'd0);
    chk("st_req_ready", 64'(req_ready), 64'd1);

    // undefined opcode
    issue(5'b11100, 32'd0, 32'd0, 4'd0);
    tick();
    tick();
    chk("err_not_yet", 64'(op_err), 64'd0);
    tick();
    chk("err_flag", {61'd0, op_err, wb_valid, busy}, 64'd4);

    // clear while the HI beat is stalled
    wb_ready = 1'b0;
    alu_c    = 64'h0000_0001_8000_0000;
    issue(5'b01110, 32'd2, 32'd3, 4'd0);
    tick();
    tick();
    tick();
    chk("rmid_pre", {wb_valid, 31'd0, 30'd0, wb_sel}, {1'b1, 31'd0, 30'd0, 2'd1});
    #2;
    clear = 1'b1;
    #1;
    chk("rmid_wb_valid", 64'(wb_valid), 64'd0);
    chk("rmid_busy", 64'(busy), 64'd0);
    chk("rmid_flags", {62'd0, halted, op_err}, 64'd0);
    #1;
    clear = 1'b0;
    tick();
    chk("rmid_req_ready", 64'(req_ready), 64'd1);
    wb_ready = 1'b1;
    alu_c    = 64'd12;
    issue(5'b00011, 32'd5, 32'd7, 4'd3);
    tick();
    tick();
    tick();
    chk("rmid_add_beat", {wb_valid, 25'd0, wb_sel, wb_addr, wb_data}, {1'b1, 25'd0, 2'd0, 4'd3, 32'd12});
    tick();
    chk("rmid_add_done", {62'd0, wb_valid, busy}, 64'd0);

    // halt, then a request that must be refused
    issue(5'b11010, 32'd0, 32'd0, 4'd0);
    tick();
    tick();
    tick();
    chk("halt_flag", {61'd0, halted, wb_valid, busy}, 64'd4);
    chk("halt_req_ready", 64'(req_ready), 64'd0);
    req_valid  = 1'b1;
    req_opcode = 5'b00011;
    req_a      = 32'd9;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("halt_refuse%0d", i), {61'd0, req_ready, busy, wb_valid}, 64'd0);
      chk($sformatf("halt_alu_kept%0d", i), 64'(alu_opcode), 64'h1A);
    end
    req_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
